// File: rtl/bp_me_mem_arb_pkg.sv
// bp_me_mem_arb_pkg
//   Shared types for the memory-port arbiter slice.
//   - arb_state_e : command FSM state (IDLE / BURST)
//   - arb_tag_t   : requester index carried through the tag FIFO.
//                   It is sized for the largest legal num_req_p (8).
//   - arb_tag_next: round-robin successor of a requester index.
package bp_me_mem_arb_pkg;

    typedef enum logic [0:0] {
        E_IDLE  = 1'b0,
        E_BURST = 1'b1
    } arb_state_e;

    localparam int unsigned arb_max_req_lp   = 32'd8;
    localparam int unsigned arb_tag_width_lp = $clog2(arb_max_req_lp);

    typedef logic [arb_tag_width_lp-1:0] arb_tag_t;

    // Next requester after tag, wrapping at n requesters
    function automatic arb_tag_t arb_tag_next(input arb_tag_t tag, input int unsigned n);
        arb_tag_t nxt;
        if ((32'(tag) + 32'd1) >= n) begin
            nxt = '0;
        end else begin
            nxt = tag + arb_tag_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_me_mem_arb_chk.sv
// bp_me_mem_arb_chk
//   Simulation checker: flags a memory response arriving while no command
//   is outstanding (the response would have no destination).
//   Ports: clk_i, reset_i, mem_resp_v_i, fifo_empty_i.
module bp_me_mem_arb_chk (
    input logic clk_i,
    input logic reset_i,
    input logic mem_resp_v_i,
    input logic fifo_empty_i
);

    property p_no_orphan_resp;
        @(posedge clk_i) disable iff (!reset_i) !(mem_resp_v_i && fifo_empty_i);
    endproperty

    a_no_orphan_resp: assert property (p_no_orphan_resp)
        else $error("bp_me_mem_arb: memory response with no outstanding command");

endmodule

// File: rtl/bp_me_mem_arb_tag_fifo.sv
// bp_me_mem_arb_tag_fifo
//   depth_p-entry FIFO of requester tags, one entry per memory command in
//   flight. The head tag names the requester owning the next response.
//   Ports: clk_i, reset_i (async, active-low), push_i/tag_i (enqueue),
//          pop_i (dequeue), head_o (oldest tag), full_o, empty_o.
//   A push while full or a pop while empty is ignored.
module bp_me_mem_arb_tag_fifo
    import bp_me_mem_arb_pkg::*;
#(
    parameter int depth_p = 4
)(
    input  logic     clk_i,
    input  logic     reset_i,
    input  logic     push_i,
    input  arb_tag_t tag_i,
    input  logic     pop_i,
    output arb_tag_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int ptr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int cnt_w_lp = $clog2(depth_p + 1);
    localparam logic [cnt_w_lp-1:0] depth_lp = cnt_w_lp'(depth_p);
    localparam logic [ptr_w_lp-1:0] last_lp  = ptr_w_lp'(depth_p - 1);

    arb_tag_t [depth_p-1:0] r_mem;
    logic [ptr_w_lp-1:0]    r_wptr;
    logic [ptr_w_lp-1:0]    r_rptr;
    logic [cnt_w_lp-1:0]    r_count;
    logic                   w_push;
    logic                   w_pop;

    assign full_o  = (r_count == depth_lp);
    assign empty_o = (r_count == cnt_w_lp'(0));
    assign head_o  = r_mem[r_rptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    // Storage, pointers (explicit wrap) and occupancy
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_mem   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= tag_i;
                r_wptr        <= (r_wptr == last_lp) ? ptr_w_lp'(0) : r_wptr + ptr_w_lp'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == last_lp) ? ptr_w_lp'(0) : r_rptr + ptr_w_lp'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cnt_w_lp'(1);
                2'b01:   r_count <= r_count - cnt_w_lp'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bp_me_mem_arb.sv
// bp_me_mem_arb
//   Shares one BedRock memory port among num_req_p cache requesters.
//   Commands: round-robin grant in IDLE (zero-cycle), multi-beat bursts
//   locked to the winner in BURST. Each granted command pushes the
//   winner's index into a tag FIFO; in-order responses are routed to the
//   FIFO head and the tag is popped on the last response beat.
//   Ports: clk_i, reset_i (async, active-low);
//          req_cmd_*  : per-requester command streams in, ready out;
//          req_resp_* : broadcast response header/data, one-hot valid;
//          mem_cmd_*  : shared memory command stream out;
//          mem_resp_* : shared memory response stream in;
//          stat_o     : per-requester granted-command counts.
//   Option: BP_ME_MEM_ARB_STATS_EN enables the saturating stat_o counters;
//           otherwise stat_o is constant zero.
module bp_me_mem_arb
    import bp_me_mem_arb_pkg::*;
#(
    parameter int num_req_p      = 2,
    parameter int header_width_p = 64,
    parameter int data_width_p   = 64,
    parameter int outstanding_p  = 4
)(
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [num_req_p-1:0][header_width_p-1:0] req_cmd_header_i,
    input  logic [num_req_p-1:0][data_width_p-1:0]   req_cmd_data_i,
    input  logic [num_req_p-1:0]                     req_cmd_v_i,
    input  logic [num_req_p-1:0]                     req_cmd_last_i,
    output logic [num_req_p-1:0]                     req_cmd_ready_and_o,
    output logic [header_width_p-1:0]                req_resp_header_o,
    output logic [data_width_p-1:0]                  req_resp_data_o,
    output logic [num_req_p-1:0]                     req_resp_v_o,
    output logic                                     req_resp_last_o,
    input  logic [num_req_p-1:0]                     req_resp_ready_and_i,
    output logic [header_width_p-1:0]                mem_cmd_header_o,
    output logic [data_width_p-1:0]                  mem_cmd_data_o,
    output logic                                     mem_cmd_v_o,
    output logic                                     mem_cmd_last_o,
    input  logic                                     mem_cmd_ready_and_i,
    input  logic [header_width_p-1:0]                mem_resp_header_i,
    input  logic [data_width_p-1:0]                  mem_resp_data_i,
    input  logic                                     mem_resp_v_i,
    input  logic                                     mem_resp_last_i,
    output logic                                     mem_resp_ready_and_o,
    output logic [num_req_p-1:0][31:0]               stat_o
);

    arb_state_e                r_state;
    arb_tag_t                  r_owner;
    arb_tag_t                  r_rr;
    arb_tag_t                  w_pick;
    logic                      w_pick_v;
    arb_tag_t                  w_win;
    logic [num_req_p-1:0]      w_win_oh;
    logic                      w_gnt_v;
    logic [header_width_p-1:0] w_cmd_hdr;
    logic [data_width_p-1:0]   w_cmd_data;
    logic                      w_cmd_v;
    logic                      w_cmd_last;
    logic                      w_cmd_hs;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    arb_tag_t                  w_head;
    logic [num_req_p-1:0]      w_head_oh;
    logic                      w_resp_sel;

    // Round-robin pick: the valid requester closest at or after r_rr wins
    always_comb begin
        int w_best;
        int w_dist;
        w_best   = num_req_p;
        w_dist   = 0;
        w_pick   = '0;
        w_pick_v = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            w_dist = (i + num_req_p - int'(r_rr)) % num_req_p;
            if (req_cmd_v_i[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_pick   = arb_tag_t'(i);
                w_pick_v = 1'b1;
            end else begin
                w_best   = w_best;
            end
        end
    end

    // A full FIFO only blocks new grants; an open burst already owns a slot
    assign w_win   = (r_state == E_BURST) ? r_owner : w_pick;
    assign w_gnt_v = reset_i & ((r_state == E_BURST) | (w_pick_v & ~w_fifo_full));

    // Route the winner's command stream to the memory port
    always_comb begin
        w_win_oh   = '0;
        w_cmd_hdr  = '0;
        w_cmd_data = '0;
        w_cmd_v    = 1'b0;
        w_cmd_last = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (w_win == arb_tag_t'(i)) begin
                w_win_oh[i] = 1'b1;
                w_cmd_hdr   = req_cmd_header_i[i];
                w_cmd_data  = req_cmd_data_i[i];
                w_cmd_v     = req_cmd_v_i[i];
                w_cmd_last  = req_cmd_last_i[i];
            end else begin
                w_win_oh[i] = 1'b0;
            end
        end
    end

    assign mem_cmd_header_o    = w_cmd_hdr;
    assign mem_cmd_data_o      = w_cmd_data;
    assign mem_cmd_v_o         = w_gnt_v & w_cmd_v;
    assign mem_cmd_last_o      = w_gnt_v & w_cmd_last;
    assign req_cmd_ready_and_o = (w_gnt_v & mem_cmd_ready_and_i) ? w_win_oh : '0;
    assign w_cmd_hs            = mem_cmd_v_o & mem_cmd_ready_and_i;
    assign w_push              = w_cmd_hs & (r_state == E_IDLE);

    // Command FSM: burst lock and round-robin pointer advance
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= E_IDLE;
            r_owner <= '0;
            r_rr    <= '0;
        end else begin
            case (r_state)
                E_IDLE: begin
                    if (w_cmd_hs && mem_cmd_last_o) begin
                        r_rr <= arb_tag_next(w_win, num_req_p);
                    end else if (w_cmd_hs) begin
                        r_state <= E_BURST;
                        r_owner <= w_win;
                    end
                end
                E_BURST: begin
                    if (w_cmd_hs && mem_cmd_last_o) begin
                        r_state <= E_IDLE;
                        r_rr    <= arb_tag_next(r_owner, num_req_p);
                    end
                end
                default: r_state <= E_IDLE;
            endcase
        end
    end

    bp_me_mem_arb_tag_fifo #(
        .depth_p (outstanding_p)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_push),
        .tag_i   (w_win),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    bp_me_mem_arb_chk u_chk (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .mem_resp_v_i (mem_resp_v_i),
        .fifo_empty_i (w_fifo_empty)
    );

    // Decode the FIFO head into a one-hot response destination
    always_comb begin
        w_head_oh = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (w_head == arb_tag_t'(i)) begin
                w_head_oh[i] = 1'b1;
            end else begin
                w_head_oh[i] = 1'b0;
            end
        end
    end

    // With no outstanding tag the response is neither routed nor accepted
    assign w_resp_sel           = reset_i & ~w_fifo_empty;
    assign req_resp_header_o    = mem_resp_header_i;
    assign req_resp_data_o      = mem_resp_data_i;
    assign req_resp_last_o      = mem_resp_last_i;
    assign req_resp_v_o         = (w_resp_sel & mem_resp_v_i) ? w_head_oh : '0;
    assign mem_resp_ready_and_o = w_resp_sel & (|(req_resp_ready_and_i & w_head_oh));
    assign w_pop                = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;

`ifdef BP_ME_MEM_ARB_STATS_EN
    logic [num_req_p-1:0][31:0] r_stat;

    // Saturating count of first-beat grants per requester
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_stat <= '0;
        end else begin
            for (int i = 0; i < num_req_p; i++) begin
                if (w_push && w_win_oh[i] && (r_stat[i] != 32'hFFFF_FFFF)) begin
                    r_stat[i] <= r_stat[i] + 32'd1;
                end
            end
        end
    end

    assign stat_o = r_stat;
`else
    assign stat_o = '0;
`endif

endmodule

// File: tb/tb_bp_me_mem_arb.sv
module tb_bp_me_mem_arb;

    localparam int NR = 2;
    localparam int HW = 64;
    localparam int DW = 64;
    localparam int OS = 4;

    logic                   clk_i;
    logic                   reset_i;
    logic [NR-1:0][HW-1:0]  req_cmd_header_i;
    logic [NR-1:0][DW-1:0]  req_cmd_data_i;
    logic [NR-1:0]          req_cmd_v_i;
    logic [NR-1:0]          req_cmd_last_i;
    logic [NR-1:0]          req_cmd_ready_and_o;
    logic [HW-1:0]          req_resp_header_o;
    logic [DW-1:0]          req_resp_data_o;
    logic [NR-1:0]          req_resp_v_o;
    logic                   req_resp_last_o;
    logic [NR-1:0]          req_resp_ready_and_i;
    logic [HW-1:0]          mem_cmd_header_o;
    logic [DW-1:0]          mem_cmd_data_o;
    logic                   mem_cmd_v_o;
    logic                   mem_cmd_last_o;
    logic                   mem_cmd_ready_and_i;
    logic [HW-1:0]          mem_resp_header_i;
    logic [DW-1:0]          mem_resp_data_i;
    logic                   mem_resp_v_i;
    logic                   mem_resp_last_i;
    logic                   mem_resp_ready_and_o;
    logic [NR-1:0][31:0]    stat_o;

    int total;
    int bad;

    bp_me_mem_arb #(
        .num_req_p(NR), .header_width_p(HW), .data_width_p(DW), .outstanding_p(OS)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_cmd_header_i(req_cmd_header_i), .req_cmd_data_i(req_cmd_data_i),
        .req_cmd_v_i(req_cmd_v_i), .req_cmd_last_i(req_cmd_last_i),
        .req_cmd_ready_and_o(req_cmd_ready_and_o),
        .req_resp_header_o(req_resp_header_o), .req_resp_data_o(req_resp_data_o),
        .req_resp_v_o(req_resp_v_o), .req_resp_last_o(req_resp_last_o),
        .req_resp_ready_and_i(req_resp_ready_and_i),
        .mem_cmd_header_o(mem_cmd_header_o), .mem_cmd_data_o(mem_cmd_data_o),
        .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_last_o(mem_cmd_last_o),
        .mem_cmd_ready_and_i(mem_cmd_ready_and_i),
        .mem_resp_header_i(mem_resp_header_i), .mem_resp_data_i(mem_resp_data_i),
        .mem_resp_v_i(mem_resp_v_i), .mem_resp_last_i(mem_resp_last_i),
        .mem_resp_ready_and_o(mem_resp_ready_and_o),
        .stat_o(stat_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        reset_i = 1'b0;
        req_cmd_v_i = 2'b00;
        req_cmd_last_i = 2'b00;
        mem_resp_v_i = 1'b0;
        mem_resp_last_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        req_cmd_header_i[0] = 64'h0000_0000_0000_00A0;
        req_cmd_header_i[1] = 64'h0000_0000_0000_00B1;
        req_cmd_data_i[0] = 64'h1111_1111_1111_1111;
        req_cmd_data_i[1] = 64'h2222_2222_2222_2222;
        req_cmd_v_i = 2'b11;
        req_cmd_last_i = 2'b11;
        mem_cmd_ready_and_i = 1'b1;
        mem_resp_header_i = 64'h0;
        mem_resp_data_i = 64'h0;
        mem_resp_v_i = 1'b1;
        mem_resp_last_i = 1'b1;
        req_resp_ready_and_i = 2'b11;
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (req_cmd_ready_and_o !== 2'b00) begin bad++; $display("FAIL reset_cmd_ready: got %b want 00", req_cmd_ready_and_o); end
        total++; if (mem_cmd_v_o !== 1'b0) begin bad++; $display("FAIL reset_mem_cmd_v: got %b want 0", mem_cmd_v_o); end
        total++; if (req_resp_v_o !== 2'b00) begin bad++; $display("FAIL reset_resp_v: got %b want 00", req_resp_v_o); end
        total++; if (mem_resp_ready_and_o !== 1'b0) begin bad++; $display("FAIL reset_mem_resp_ready: got %b want 0", mem_resp_ready_and_o); end
        total++; if (stat_o !== 64'h0) begin bad++; $display("FAIL reset_stat: got %h want 0", stat_o); end
        apply_reset();
    endtask

    task automatic test_round_robin();
        req_cmd_v_i = 2'b11;
        req_cmd_last_i = 2'b11;
        #1;
        total++; if (req_cmd_ready_and_o !== 2'b01) begin bad++; $display("FAIL rr_first_ready: got %b want 01", req_cmd_ready_and_o); end
        total++; if (mem_cmd_header_o !== 64'h00A0) begin bad++; $display("FAIL rr_first_hdr: got %h want a0", mem_cmd_header_o); end
        total++; if (mem_cmd_data_o !== 64'h1111_1111_1111_1111) begin bad++; $display("FAIL rr_first_data: got %h want 1111111111111111", mem_cmd_data_o); end
        step();
        total++; if (req_cmd_ready_and_o !== 2'b10) begin bad++; $display("FAIL rr_second_ready: got %b want 10", req_cmd_ready_and_o); end
        total++; if (mem_cmd_header_o !== 64'h00B1) begin bad++; $display("FAIL rr_second_hdr: got %h want b1", mem_cmd_header_o); end
        step();
        req_cmd_v_i = 2'b00;
        mem_resp_v_i = 1'b1;
        mem_resp_last_i = 1'b1;
        mem_resp_data_i = 64'h0000_0000_0000_00D0;
        req_resp_ready_and_i = 2'b11;
        #1;
        total++; if (req_resp_v_o !== 2'b01) begin bad++; $display("FAIL rr_resp0_v: got %b want 01", req_resp_v_o); end
        total++; if (req_resp_data_o !== 64'h00D0) begin bad++; $display("FAIL rr_resp0_data: got %h want d0", req_resp_data_o); end
        total++; if (mem_resp_ready_and_o !== 1'b1) begin bad++; $display("FAIL rr_resp0_ready: got %b want 1", mem_resp_ready_and_o); end
        step();
        total++; if (req_resp_v_o !== 2'b10) begin bad++; $display("FAIL rr_resp1_v: got %b want 10", req_resp_v_o); end
        step();
        mem_resp_v_i = 1'b0;
    endtask

    task automatic test_burst();
        req_cmd_v_i = 2'b01;
        req_cmd_last_i = 2'b00;
        #1;
        total++; if (req_cmd_ready_and_o !== 2'b01) begin bad++; $display("FAIL burst_beat0_ready: got %b want 01", req_cmd_ready_and_o); end
        total++; if (mem_cmd_last_o !== 1'b0) begin bad++; $display("FAIL burst_beat0_last: got %b want 0", mem_cmd_last_o); end
        step();
        req_cmd_v_i = 2'b11;
        req_cmd_last_i = 2'b10;
        #1;
        total++; if (req_cmd_ready_and_o !== 2'b01) begin bad++; $display("FAIL burst_beat1_ready: got %b want 01", req_cmd_ready_and_o); end
        step();
        mem_cmd_ready_and_i = 1'b0;
        #1;
        total++; if (req_cmd_ready_and_o !== 2'b00) begin bad++; $display("FAIL burst_stall_ready: got %b want 00", req_cmd_ready_and_o); end
        total++; if (mem_cmd_v_o !== 1'b1) begin bad++; $display("FAIL burst_stall_v: got %b want 1", mem_cmd_v_o); end
        step();
        mem_cmd_ready_and_i = 1'b1;
        #1;
        total++; if (req_cmd_ready_and_o !== 2'b01) begin bad++; $display("FAIL burst_beat2_ready: got %b want 01", req_cmd_ready_and_o); end
        step();
        req_cmd_last_i = 2'b11;
        #1;
        total++; if (req_cmd_ready_and_o !== 2'b01) begin bad++; $display("FAIL burst_beat3_ready: got %b want 01", req_cmd_ready_and_o); end
        total++; if (mem_cmd_last_o !== 1'b1) begin bad++; $display("FAIL burst_beat3_last: got %b want 1", mem_cmd_last_o); end
        step();
        total++; if (req_cmd_ready_and_o !== 2'b10) begin bad++; $display("FAIL burst_next_winner: got %b want 10", req_cmd_ready_and_o); end
        step();
        req_cmd_v_i = 2'b00;
    endtask

    task automatic test_resp_stall();
        mem_resp_v_i = 1'b1;
        mem_resp_last_i = 1'b0;
        mem_resp_data_i = 64'h0000_0000_0000_00A5;
        req_resp_ready_and_i = 2'b11;
        #1;
        total++; if (req_resp_v_o !== 2'b01) begin bad++; $display("FAIL stall_multibeat0_v: got %b want 01", req_resp_v_o); end
        total++; if (req_resp_last_o !== 1'b0) begin bad++; $display("FAIL stall_multibeat0_last: got %b want 0", req_resp_last_o); end
        step();
        mem_resp_last_i = 1'b1;
        #1;
        total++; if (req_resp_v_o !== 2'b01) begin bad++; $display("FAIL stall_multibeat1_v: got %b want 01", req_resp_v_o); end
        step();
        req_resp_ready_and_i = 2'b01;
        mem_resp_data_i = 64'h0000_0000_0000_00C1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (mem_resp_ready_and_o !== 1'b0) begin bad++; $display("FAIL stall_hold_ready cyc%0d: got %b want 0", i, mem_resp_ready_and_o); end
            total++; if (req_resp_v_o !== 2'b10) begin bad++; $display("FAIL stall_hold_v cyc%0d: got %b want 10", i, req_resp_v_o); end
            step();
        end
        req_resp_ready_and_i = 2'b11;
        #1;
        total++; if (mem_resp_ready_and_o !== 1'b1) begin bad++; $display("FAIL stall_release_ready: got %b want 1", mem_resp_ready_and_o); end
        total++; if (req_resp_data_o !== 64'h00C1) begin bad++; $display("FAIL stall_release_data: got %h want c1", req_resp_data_o); end
        step();
        mem_resp_v_i = 1'b0;
    endtask

    task automatic test_fifo_full();
        req_cmd_v_i = 2'b01;
        req_cmd_last_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (req_cmd_ready_and_o !== 2'b01) begin bad++; $display("FAIL full_fill_ready cmd%0d: got %b want 01", i, req_cmd_ready_and_o); end
            step();
        end
        total++; if (req_cmd_ready_and_o !== 2'b00) begin bad++; $display("FAIL full_fifth_blocked: got %b want 00", req_cmd_ready_and_o); end
        mem_resp_v_i = 1'b1;
        mem_resp_last_i = 1'b1;
        req_resp_ready_and_i = 2'b11;
        #1;
        total++; if (req_cmd_ready_and_o !== 2'b00) begin bad++; $display("FAIL full_no_bypass: got %b want 00", req_cmd_ready_and_o); end
        total++; if (mem_resp_ready_and_o !== 1'b1) begin bad++; $display("FAIL full_resp_ready: got %b want 1", mem_resp_ready_and_o); end
        step();
        total++; if (req_cmd_ready_and_o !== 2'b01) begin bad++; $display("FAIL full_after_pop_ready: got %b want 01", req_cmd_ready_and_o); end
        step();
        mem_resp_v_i = 1'b0;
        #1;
        total++; if (req_cmd_ready_and_o !== 2'b01) begin bad++; $display("FAIL full_push_pop_same: got %b want 01", req_cmd_ready_and_o); end
        step();
        total++; if (req_cmd_ready_and_o !== 2'b00) begin bad++; $display("FAIL full_refilled: got %b want 00", req_cmd_ready_and_o); end
        req_cmd_v_i = 2'b00;
        mem_resp_v_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (req_resp_v_o !== 2'b01) begin bad++; $display("FAIL full_drain_v rsp%0d: got %b want 01", i, req_resp_v_o); end
            step();
        end
        mem_resp_v_i = 1'b0;
        #1;
        total++; if (mem_resp_ready_and_o !== 1'b0) begin bad++; $display("FAIL full_empty_ready: got %b want 0", mem_resp_ready_and_o); end
    endtask

    task automatic test_reset_midburst();
        req_cmd_v_i = 2'b01;
        req_cmd_last_i = 2'b00;
        #1;
        total++; if (req_cmd_ready_and_o !== 2'b01) begin bad++; $display("FAIL midrst_beat0_ready: got %b want 01", req_cmd_ready_and_o); end
        step();
        req_cmd_v_i = 2'b11;
        req_cmd_last_i = 2'b10;
        step();
        total++; if (req_cmd_ready_and_o !== 2'b01) begin bad++; $display("FAIL midrst_beat2_ready: got %b want 01", req_cmd_ready_and_o); end
        reset_i = 1'b0;
        #1;
        total++; if (req_cmd_ready_and_o !== 2'b00) begin bad++; $display("FAIL midrst_in_reset_ready: got %b want 00", req_cmd_ready_and_o); end
        total++; if (mem_cmd_v_o !== 1'b0) begin bad++; $display("FAIL midrst_in_reset_v: got %b want 0", mem_cmd_v_o); end
        step();
        reset_i = 1'b1;
        req_cmd_v_i = 2'b10;
        req_cmd_last_i = 2'b10;
        req_resp_ready_and_i = 2'b11;
        #1;
        total++; if (mem_resp_ready_and_o !== 1'b0) begin bad++; $display("FAIL midrst_fifo_empty: got %b want 0", mem_resp_ready_and_o); end
        total++; if (req_cmd_ready_and_o !== 2'b10) begin bad++; $display("FAIL midrst_req1_wins: got %b want 10", req_cmd_ready_and_o); end
        step();
        req_cmd_v_i = 2'b00;
        mem_resp_v_i = 1'b1;
        mem_resp_last_i = 1'b1;
        #1;
        total++; if (req_resp_v_o !== 2'b10) begin bad++; $display("FAIL midrst_resp_to_req1: got %b want 10", req_resp_v_o); end
        step();
        mem_resp_v_i = 1'b0;
    endtask

    task automatic test_stats();
        logic [NR-1:0] who;
        logic [63:0]   exp_stat;
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            who = (i < 3) ? 2'b10 : 2'b01;
            req_cmd_v_i = who;
            req_cmd_last_i = 2'b11;
            step();
            req_cmd_v_i = 2'b00;
            mem_resp_v_i = 1'b1;
            mem_resp_last_i = 1'b1;
            req_resp_ready_and_i = 2'b11;
            #1;
            total++; if (req_resp_v_o !== who) begin bad++; $display("FAIL stats_resp_route cmd%0d: got %b want %b", i, req_resp_v_o, who); end
            step();
            mem_resp_v_i = 1'b0;
        end
`ifdef BP_ME_MEM_ARB_STATS_EN
        exp_stat = {32'd3, 32'd10};
`else
        exp_stat = 64'h0;
`endif
        #1;
        total++; if (stat_o !== exp_stat) begin bad++; $display("FAIL stats_count: got %h want %h", stat_o, exp_stat); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_round_robin();
        test_burst();
        test_resp_stall();
        test_fifo_full();
        test_reset_midburst();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
